fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/fetch_skid.sv | 52 +++++
 rtl/fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants: datapath width, NOP encoding,
// fetch fault index, fetch FSM states and the IF/ID entry layout.
package pipeline_pkg;

    localparam int          DATA_WIDTH  = 64;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam int          FETCH_ERROR = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [31:0]           inst;
        logic [DATA_WIDTH-1:0] pcp;
        logic [7:0]            exc;
    } fetch_entry_t;

    // Builds an IF/ID entry; the predicted next PC is always pc+4 (wrapping).
    function automatic fetch_entry_t make_entry(input logic [DATA_WIDTH-1:0] pc,
                                                input logic [31:0]           inst,
                                                input logic [7:0]            exc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        e.pcp  = pc + DATA_WIDTH'(4);
        e.exc  = exc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching a fetch response that arrives while the
// IF/ID register is held by a stall.
module fetch_skid
    import pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t entry_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q;

    // Occupancy next state: clear beats push, push beats pop.
    always_comb begin
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (push_i) begin
            valid_d = 1'b1;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    // Occupancy flag register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register, captured on push.
    always_ff @(posedge clk) begin
        // NOTE: payload is qualified by valid_q, so it needs no reset and stays a plain enable flop.
        if (push_i && !clear_i) begin
            entry_q <= entry_i;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory request,
// fills the IF/ID register (with a one-entry skid for stalls), handles
// redirects with a drain state for an outstanding request, and raises a
// fetch fault for misaligned PCs.
module fetch_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int                    FetchError = FETCH_ERROR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  prediction_failed,
    input  logic [DATA_WIDTH-1:0] pcn,
    input  logic                  flush_if,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_rdata,
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [31:0]           if_id_inst,
    output logic [DATA_WIDTH-1:0] if_id_pcp,
    output logic [7:0]            if_id_exception
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] drain_addr_q, drain_addr_d;
    logic                  fault_q, fault_d;
    logic                  if_id_valid_q, if_id_valid_d;
    fetch_entry_t          if_id_q, if_id_d;

    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;
    logic                  hold;
    logic                  accept;
    logic                  fault;
    logic [7:0]            fault_exc;
    fetch_entry_t          resp_entry;
    logic                  skid_push, skid_pop, skid_valid;
    fetch_entry_t          skid_entry;

    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (redirect),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .entry_i (resp_entry),
        .valid_o (skid_valid),
        .entry_o (skid_entry)
    );

    // Next-state, memory request and IF/ID update logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        fault_d       = fault_q;
        if_id_valid_d = if_id_valid_q;
        if_id_d       = if_id_q;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = pc_q;

        redirect   = prediction_failed | flush_if;
        target     = flush_if ? trap_pc : pcn;
        hold       = stall & if_id_valid_q;
        fault_exc  = '0;
        fault_exc[FetchError] = 1'b1;
        resp_entry = make_entry(pc_q, imem_rdata, 8'h00);

        // A request is only issued for an aligned PC with room for its response;
        // in DRAIN the old request is kept alive at its original address.
        unique case (state_q)
            REQ:     imem_req = (pc_q[1:0] == 2'b00) && !skid_valid;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
            end
            default: imem_req = 1'b0;
        endcase

        accept = (state_q == REQ) && imem_req && imem_valid && !redirect;
        fault  = (state_q == REQ) && (pc_q[1:0] != 2'b00) && !fault_q
                 && !skid_valid && !redirect;

        // FSM transitions.
        unique case (state_q)
            IDLE:  state_d = REQ;
            REQ:   if (redirect && imem_req && !imem_valid) begin
                       state_d      = DRAIN;
                       drain_addr_d = pc_q;
                   end
            DRAIN: if (imem_valid) state_d = REQ;
            default: state_d = IDLE;
        endcase

        // PC update: redirect wins over sequential advance.
        if (redirect) begin
            pc_d = target;
        end else if (accept) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end

        // IF/ID update: redirect > hold > skid drain > new response > fault entry.
        if (redirect) begin
            if_id_valid_d = 1'b0;
            fault_d       = 1'b0;
        end else if (hold) begin
            skid_push = accept;
        end else if (skid_valid) begin
            if_id_d       = skid_entry;
            if_id_valid_d = 1'b1;
            skid_pop      = 1'b1;
        end else if (accept) begin
            if_id_d       = resp_entry;
            if_id_valid_d = 1'b1;
        end else if (fault) begin
            if_id_d       = make_entry(pc_q, NOP_INST, fault_exc);
            if_id_valid_d = 1'b1;
            fault_d       = 1'b1;
        end else begin
            if_id_valid_d = 1'b0;
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            drain_addr_q  <= '0;
            fault_q       <= 1'b0;
            if_id_valid_q <= 1'b0;
            if_id_q       <= '{pc: '0, inst: NOP_INST, pcp: '0, exc: '0};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            fault_q       <= fault_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_q       <= if_id_d;
        end
    end

    assign if_id_valid     = if_id_valid_q;
    assign if_id_pc        = if_id_q.pc;
    assign if_id_inst      = if_id_q.inst;
    assign if_id_pcp       = if_id_q.pcp;
    assign if_id_exception = if_id_q.exc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small latency-programmable memory
// model whose word at address A is 32'hAAAA_0001 + A[31:0].
module tb_fetch_ctrl;
    import pipeline_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic                  prediction_failed;
    logic [DATA_WIDTH-1:0] pcn;
    logic                  flush_if;
    logic [DATA_WIDTH-1:0] trap_pc;
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_valid;
    logic [31:0]           imem_rdata;
    logic                  if_id_valid;
    logic [DATA_WIDTH-1:0] if_id_pc;
    logic [31:0]           if_id_inst;
    logic [DATA_WIDTH-1:0] if_id_pcp;
    logic [7:0]            if_id_exception;

    int passed = 0;
    int total  = 0;
    int lat    = 0;
    int wait_cnt = 0;

    fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .prediction_failed (prediction_failed),
        .pcn               (pcn),
        .flush_if          (flush_if),
        .trap_pc           (trap_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_valid        (imem_valid),
        .imem_rdata        (imem_rdata),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_inst        (if_id_inst),
        .if_id_pcp         (if_id_pcp),
        .if_id_exception   (if_id_exception)
    );

    always #5 clk = ~clk;

    // Memory: answers after 'lat' waiting cycles of a held request.
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt >= lat) begin
                imem_valid = 1'b1;
                imem_rdata = 32'hAAAA_0001 + imem_addr[31:0];
                wait_cnt   = 0;
            end else begin
                imem_valid = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            imem_valid = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then one more edge so the FSM is in REQ.
    task automatic reset_seq(input int l);
        lat = l;
        stall = 1'b0; prediction_failed = 1'b0; flush_if = 1'b0;
        pcn = '0; trap_pc = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        lat = 0;
        stall = 1'b0; prediction_failed = 1'b0; flush_if = 1'b0;
        pcn = '0; trap_pc = '0;
        rst = 1'b1;
        tick();
        tick();
        total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_id_valid); else passed++;
        total++; if (if_id_pc !== 64'h0) $display("FAIL reset_pc: got %h want 0", if_id_pc); else passed++;
        total++; if (if_id_inst !== 32'h0000_0013) $display("FAIL reset_inst: got %h want 00000013", if_id_inst); else passed++;
        total++; if (if_id_pcp !== 64'h0) $display("FAIL reset_pcp: got %h want 0", if_id_pcp); else passed++;
        total++; if (if_id_exception !== 8'h00) $display("FAIL reset_exc: got %h want 00", if_id_exception); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passed++;
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        tick();
        total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== 64'h0) $display("FAIL first_addr: got %h want 0", imem_addr); else passed++;
        tick();
        total++; if (if_id_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", if_id_valid); else passed++;
        total++; if (if_id_pc !== 64'h0) $display("FAIL first_pc: got %h want 0", if_id_pc); else passed++;
        total++; if (if_id_inst !== 32'hAAAA_0001) $display("FAIL first_inst: got %h want AAAA0001", if_id_inst); else passed++;
        total++; if (if_id_pcp !== 64'h4) $display("FAIL first_pcp: got %h want 4", if_id_pcp); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_pc [4];
        logic [31:0] exp_inst [4];
        exp_pc   = '{64'h0, 64'h4, 64'h8, 64'hC};
        exp_inst = '{32'hAAAA_0001, 32'hAAAA_0005, 32'hAAAA_0009, 32'hAAAA_000D};
        reset_seq(0);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (if_id_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, if_id_valid); else passed++;
            total++; if (if_id_pc !== exp_pc[i]) $display("FAIL b2b_pc[%0d]: got %h want %h", i, if_id_pc, exp_pc[i]); else passed++;
            total++; if (if_id_inst !== exp_inst[i]) $display("FAIL b2b_inst[%0d]: got %h want %h", i, if_id_inst, exp_inst[i]); else passed++;
        end
    endtask

    task automatic test_stall();
        reset_seq(0);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (if_id_pc !== 64'h0) $display("FAIL stall_hold_pc[%0d]: got %h want 0", i, if_id_pc); else passed++;
            total++; if (imem_req !== 1'b0) $display("FAIL stall_no_req[%0d]: got %b want 0", i, imem_req); else passed++;
        end
        stall = 1'b0;
        tick();
        total++; if (if_id_pc !== 64'h4) $display("FAIL stall_skid_pc: got %h want 4", if_id_pc); else passed++;
        total++; if (if_id_inst !== 32'hAAAA_0005) $display("FAIL stall_skid_inst: got %h want AAAA0005", if_id_inst); else passed++;
        total++; if (imem_addr !== 64'h8 || imem_req !== 1'b1) $display("FAIL stall_resume_req: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); else passed++;
        tick();
        total++; if (if_id_pc !== 64'h8 || if_id_valid !== 1'b1) $display("FAIL stall_next_pc: got valid=%b pc=%h want valid=1 pc=8", if_id_valid, if_id_pc); else passed++;
    endtask

    task automatic test_drain();
        reset_seq(2);
        prediction_failed = 1'b1;
        pcn = 64'h100;
        tick();
        prediction_failed = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) $display("FAIL drain_old_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL drain_valid0: got %b want 0", if_id_valid); else passed++;
        tick();
        tick();
        total++; if (if_id_valid !== 1'b0) $display("FAIL drain_discard: got %b want 0", if_id_valid); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) $display("FAIL drain_new_addr: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (if_id_valid !== 1'b0) $display("FAIL drain_wait[%0d]: got %b want 0", i, if_id_valid); else passed++;
        end
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h100) $display("FAIL drain_target_pc: got valid=%b pc=%h want valid=1 pc=100", if_id_valid, if_id_pc); else passed++;
        total++; if (if_id_inst !== 32'hAAAA_0101) $display("FAIL drain_target_inst: got %h want AAAA0101", if_id_inst); else passed++;
    endtask

    task automatic test_flush_priority();
        reset_seq(0);
        flush_if = 1'b1;
        prediction_failed = 1'b1;
        trap_pc = 64'h200;
        pcn = 64'h300;
        tick();
        flush_if = 1'b0;
        prediction_failed = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) $display("FAIL flush_addr: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL flush_valid0: got %b want 0", if_id_valid); else passed++;
        tick();
        total++; if (if_id_pc !== 64'h200 || if_id_inst !== 32'hAAAA_0201) $display("FAIL flush_entry: got pc=%h inst=%h want pc=200 inst=AAAA0201", if_id_pc, if_id_inst); else passed++;
    endtask

    task automatic test_misaligned();
        reset_seq(0);
        prediction_failed = 1'b1;
        pcn = 64'h102;
        tick();
        prediction_failed = 1'b0;
        total++; if (imem_req !== 1'b0) $display("FAIL mis_no_req: got %b want 0", imem_req); else passed++;
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h102) $display("FAIL mis_entry: got valid=%b pc=%h want valid=1 pc=102", if_id_valid, if_id_pc); else passed++;
        total++; if (if_id_inst !== 32'h0000_0013) $display("FAIL mis_inst: got %h want 00000013", if_id_inst); else passed++;
        total++; if (if_id_exception !== 8'h01) $display("FAIL mis_exc: got %h want 01", if_id_exception); else passed++;
        total++; if (if_id_pcp !== 64'h106) $display("FAIL mis_pcp: got %h want 106", if_id_pcp); else passed++;
        tick();
        total++; if (imem_req !== 1'b0) $display("FAIL mis_still_no_req: got %b want 0", imem_req); else passed++;
    endtask

    task automatic test_wrap();
        reset_seq(0);
        prediction_failed = 1'b1;
        pcn = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        prediction_failed = 1'b0;
        tick();
        total++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc: got %h want FFFFFFFFFFFFFFFC", if_id_pc); else passed++;
        total++; if (if_id_pcp !== 64'h0) $display("FAIL wrap_pcp: got %h want 0", if_id_pcp); else passed++;
        total++; if (if_id_inst !== 32'hAAA9_FFFD) $display("FAIL wrap_inst: got %h want AAA9FFFD", if_id_inst); else passed++;
        total++; if (imem_addr !== 64'h0) $display("FAIL wrap_next_addr: got %h want 0", imem_addr); else passed++;
    endtask

    task automatic test_reset_mid_request();
        reset_seq(5);
        tick();
        total++; if (imem_req !== 1'b1) $display("FAIL midrst_req_before: got %b want 1", imem_req); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (imem_req !== 1'b0) $display("FAIL midrst_req_dropped: got %b want 0", imem_req); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; prediction_failed = 1'b0; flush_if = 1'b0;
        pcn = '0; trap_pc = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_stall();
        test_drain();
        test_flush_priority();
        test_misaligned();
        test_wrap();
        test_reset_mid_request();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
